// File: rtl/npu_mmio_array.sv
// npu_mmio_array: memory-mapped N-lane signed MAC array.
// Software fills the weight/input/broadcast buffers, writes START, and the
// sequencer steps through KK taps, one per cycle, with all lanes in parallel.
// Status, run counter and per-lane results are readable over the SRAM-like
// port, which has a registered read path with one cycle of latency.
module npu_mmio_array #(
  parameter int N          = 10,
  parameter int K_SIZE     = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int AXI_WIDTH  = 32,
  parameter int ADDR_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic [3:0]           wen_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [AXI_WIDTH-1:0] wdata_i,
  output logic [AXI_WIDTH-1:0] rdata_o,
  output logic                 irq_o
);

  localparam int KK     = K_SIZE * K_SIZE;
  localparam int NKK    = N * KK;
  localparam int TAP_W  = (KK  > 1) ? $clog2(KK)  : 1;
  localparam int IDX_W  = (NKK > 1) ? $clog2(NKK) : 1;
  localparam int LANE_W = (N   > 1) ? $clog2(N)   : 1;

  localparam int A_CTRL   = 'h000;
  localparam int A_STATUS = 'h001;
  localparam int A_RUNCNT = 'h002;
  localparam int A_RESULT = 'h020;
  localparam int A_WGT    = 'h080;
  localparam int A_INP    = 'h100;
  localparam int A_BCAST  = 'h180;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [TAP_W-1:0]            tap_q, tap_d;
  logic                        mode_q, irq_en_q, done_q, err_q;
  logic [31:0]                 runcnt_q;
  logic signed [DATA_WIDTH-1:0] wgt   [NKK];
  logic signed [DATA_WIDTH-1:0] inp   [NKK];
  logic signed [DATA_WIDTH-1:0] bcast [KK];
  logic signed [ACC_WIDTH-1:0]  acc   [N];

  logic                 busy, wr, rd, last_tap;
  logic                 hit_ctrl, hit_status, hit_runcnt, hit_result;
  logic                 hit_wgt, hit_inp, hit_bcast;
  logic [IDX_W-1:0]     off_wgt, off_inp;
  logic [TAP_W-1:0]     off_bcast;
  logic [LANE_W-1:0]    off_result;
  logic                 ctrl_wr, start_ok, buf_wr, err_set, err_clr;
  logic [AXI_WIDTH-1:0] rd_val;
  logic                 unused_bits;

  // One signed product, sign-extended into the accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] w,
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(w) * (2*DATA_WIDTH)'(x);
    return ACC_WIDTH'(p);
  endfunction

  assign busy        = (state_q == S_RUN);
  assign wr          = req_i & (|wen_i);
  assign rd          = req_i & ~(|wen_i);
  assign last_tap    = busy && (tap_q == TAP_W'(KK - 1));
  assign unused_bits = ^wdata_i[AXI_WIDTH-1:DATA_WIDTH];

  // Address decode: region hits and in-region offsets.
  always_comb begin
    int a;
    a          = int'(addr_i);
    hit_ctrl   = (a == A_CTRL);
    hit_status = (a == A_STATUS);
    hit_runcnt = (a == A_RUNCNT);
    hit_result = (a >= A_RESULT) && (a < A_RESULT + N);
    hit_wgt    = (a >= A_WGT)    && (a < A_WGT + NKK);
    hit_inp    = (a >= A_INP)    && (a < A_INP + NKK);
    hit_bcast  = (a >= A_BCAST)  && (a < A_BCAST + KK);
    off_result = LANE_W'(a - A_RESULT);
    off_wgt    = IDX_W'(a - A_WGT);
    off_inp    = IDX_W'(a - A_INP);
    off_bcast  = TAP_W'(a - A_BCAST);
  end

  // Write qualification: buffers and START are locked out while a run is active.
  always_comb begin
    ctrl_wr  = wr & hit_ctrl;
    start_ok = ctrl_wr & wdata_i[0] & ~busy;
    buf_wr   = wr & (hit_wgt | hit_inp | hit_bcast) & ~busy;
    err_set  = wr & busy & ((hit_ctrl & wdata_i[0]) | hit_wgt | hit_inp | hit_bcast);
    err_clr  = wr & hit_status & wdata_i[2];
  end

  // Sequencer next state: IDLE waits for START, RUN walks taps 0..KK-1.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          tap_d   = '0;
        end
      end
      S_RUN: begin
        if (last_tap) begin
          state_d = S_IDLE;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tap_d   = '0;
      end
    endcase
  end

  // Sequencer state and tap counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  // Control/status registers; run completion setting DONE beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      runcnt_q <= '0;
    end else begin
      if (ctrl_wr) begin
        irq_en_q <= wdata_i[3];
        if (!busy) mode_q <= wdata_i[1];
      end
      if (last_tap) done_q <= 1'b1;
      else if (start_ok || (ctrl_wr && wdata_i[2])) done_q <= 1'b0;
      if (err_set) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (last_tap) runcnt_q <= runcnt_q + 32'd1;
    end
  end

  // Weight, per-lane input and broadcast buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NKK; i++) begin
        wgt[i] <= '0;
        inp[i] <= '0;
      end
      for (int t = 0; t < KK; t++) bcast[t] <= '0;
    end else if (buf_wr) begin
      if (hit_wgt)   wgt[off_wgt]     <= wdata_i[DATA_WIDTH-1:0];
      if (hit_inp)   inp[off_inp]     <= wdata_i[DATA_WIDTH-1:0];
      if (hit_bcast) bcast[off_bcast] <= wdata_i[DATA_WIDTH-1:0];
    end
  end

  // Lane accumulators: cleared on START, one tap per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < N; l++) acc[l] <= '0;
    end else if (start_ok) begin
      for (int l = 0; l < N; l++) acc[l] <= '0;
    end else if (busy) begin
      for (int l = 0; l < N; l++) begin
        acc[l] <= acc[l] + mac_term(wgt[IDX_W'(l*KK + int'(tap_q))],
                                    mode_q ? bcast[tap_q]
                                           : inp[IDX_W'(l*KK + int'(tap_q))]);
      end
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    if (hit_ctrl)        rd_val = AXI_WIDTH'({irq_en_q, 1'b0, mode_q, 1'b0});
    else if (hit_status) rd_val = AXI_WIDTH'({err_q, done_q, busy});
    else if (hit_runcnt) rd_val = AXI_WIDTH'(runcnt_q);
    else if (hit_result) rd_val = AXI_WIDTH'(acc[off_result]);
    else if (hit_wgt)    rd_val = AXI_WIDTH'(wgt[off_wgt]);
    else if (hit_inp)    rd_val = AXI_WIDTH'(inp[off_inp]);
    else if (hit_bcast)  rd_val = AXI_WIDTH'(bcast[off_bcast]);
  end

  // Registered read data; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_o <= '0;
    else if (rd) rdata_o <= rd_val;
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_o <= 1'b0;
    else        irq_o <= done_q & irq_en_q;
  end

endmodule
